aes_stream_host: RTL and testbench

AES_STREAM_HOST -- requirements
Module: aes_stream_host

---
 rtl/aes_stream_host.sv | 124 ++++++++++++
 tb/tb_aes_stream_host.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_host.sv
// aes_stream_host: bridges a 128-bit key/plaintext request to the byte-serial
// FIFO interface of an AES-128 core and assembles the 16-byte ciphertext reply.
//
// state | meaning
// IDLE  | waiting for a host request; req_ready high
// SEND  | pushing 16 {flag, key byte, data byte} words into the core's TX FIFO
// RECV  | popping 16 ciphertext bytes from the core's RX FIFO
// DONE  | ciphertext presented to the host until rsp_ready
module aes_stream_host #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_BYTES  = 16,
    parameter logic [15:0] LAST_FLAG  = 16'h1111
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [127:0]          req_key,
    input  logic [127:0]          req_data,
    input  logic                  tx_full,
    output logic                  tx_wr,
    output logic [DATA_WIDTH-1:0] tx_dout,
    input  logic                  rx_empty,
    output logic                  rx_rd,
    input  logic [DATA_WIDTH-1:0] rx_din,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [127:0]          rsp_data,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    // Key and data are shifted left as bytes are sent, so the current byte
    // always sits in the top eight bits and no variable indexing is needed.
    logic [127:0]     key_q;
    logic [127:0]     data_q;
    // Only 15 bytes need to be held; the 16th is taken straight from rx_din
    // when the result register is loaded.
    logic [119:0]     shift_q;
    // Separate result register so rsp_data stays put while the next block
    // is still being received.
    logic [127:0]     rsp_q;
    logic [31:0]      tx_word;
    logic             last_byte;
    logic             unused_rx_upper;

    assign last_byte       = (byte_cnt == LAST_IDX);
    assign unused_rx_upper = ^rx_din[DATA_WIDTH-1:8];

    // Sequencer: request capture, byte streaming out and in, response handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
            key_q    <= '0;
            data_q   <= '0;
            shift_q  <= '0;
            rsp_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        key_q    <= req_key;
                        data_q   <= req_data;
                        byte_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_full) begin
                        key_q  <= {key_q[119:0], 8'h00};
                        data_q <= {data_q[119:0], 8'h00};
                        if (last_byte) begin
                            byte_cnt <= '0;
                            state    <= RECV;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                RECV: begin
                    if (!rx_empty) begin
                        shift_q <= {shift_q[111:0], rx_din[7:0]};
                        if (last_byte) begin
                            rsp_q    <= {shift_q, rx_din[7:0]};
                            byte_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // TX word: flag in the upper half only on the final byte of the block.
    always_comb begin
        tx_word = {(last_byte ? LAST_FLAG : 16'h0000), key_q[127:120], data_q[127:120]};
    end

    // FIFO strobes follow the FIFO flags directly so they can never fire
    // into a full TX FIFO or out of an empty RX FIFO.
    assign tx_wr     = (state == SEND) && !tx_full;
    assign rx_rd     = (state == RECV) && !rx_empty;
    assign tx_dout   = (state == SEND) ? DATA_WIDTH'(tx_word) : '0;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_aes_stream_host.sv
// Directed testbench for aes_stream_host: table of transactions plus
// hand-written reset-abort and held-request sequences.
module tb_aes_stream_host;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_key;
    logic [127:0] req_data;
    logic         tx_full;
    logic         tx_wr;
    logic [31:0]  tx_dout;
    logic         rx_empty;
    logic         rx_rd;
    logic [31:0]  rx_din;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;
    logic         busy;

    aes_stream_host #(.DATA_WIDTH(32), .NUM_BYTES(16), .LAST_FLAG(16'h1111)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_data(req_data),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_dout(tx_dout),
        .rx_empty(rx_empty), .rx_rd(rx_rd), .rx_din(rx_din),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] rx;
        bit           stall;
        bit           rx_toggle;
        int           rsp_delay;
        bit           hold;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w3;
        logic [31:0]  exp_w15;
        int           exp_span;
        int           exp_lat;
        logic [127:0] exp_rsp;
    } vec_t;

    vec_t        vecs[4];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rd_idx = 0;
    int          tx_cnt = 0;
    int          acc_cnt = 0;
    int          viol_full = 0;
    int          viol_empty = 0;
    int          viol_ready = 0;
    logic [31:0] txlog[$];
    int          wcyc[$];
    logic [7:0]  rx_arr[16];
    bit          cur_stall = 0;
    bit          cur_toggle = 0;
    bit          ph = 0;
    int          stall_left = 0;

    assign rx_din   = {24'hA5A5A5, rx_arr[rd_idx[3:0]]};
    assign rx_empty = (rd_idx >= 16) || (cur_toggle && ph);

    // Bus monitor: logs writes, models the RX FIFO read pointer, counts illegal strobes.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (req_valid && req_ready) begin
                acc_cnt <= acc_cnt + 1;
                txlog.delete();
                wcyc.delete();
                tx_cnt <= 0;
                rd_idx <= 0;
            end
            if (tx_wr) begin
                txlog.push_back(tx_dout);
                wcyc.push_back(cyc);
                tx_cnt <= tx_cnt + 1;
                if (tx_full) viol_full <= viol_full + 1;
            end
            if (rx_rd) begin
                if (rx_empty) viol_empty <= viol_empty + 1;
                if (rd_idx < 16) rd_idx <= rd_idx + 1;
            end
        end
    end

    // Flow-control stimulus, driven away from the active edge.
    always @(negedge clock) begin
        ph = ~ph;
        if (cur_stall && tx_cnt == 3 && stall_left > 0) begin
            tx_full = 1'b1;
            stall_left = stall_left - 1;
        end else begin
            tx_full = 1'b0;
        end
        if (req_ready !== !busy) viol_ready = viol_ready + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(name, rsp_valid, 1);
    endtask

    task automatic run_txn(input vec_t v);
        int          acc;
        int          werr;
        int          bad;
        logic [31:0] e;
        logic [127:0] held;
        cur_stall  = v.stall;
        stall_left = 5;
        cur_toggle = v.rx_toggle;
        for (int i = 0; i < 16; i++) rx_arr[i] = v.rx[127-8*i -: 8];
        @(negedge clock);
        req_valid = 1'b1;
        req_key   = v.key;
        req_data  = v.data;
        @(posedge clock);
        @(negedge clock);
        acc = cyc;
        if (!v.hold) req_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        wait_rsp("rsp_timeout");
        if (v.exp_lat >= 0) chk("latency_edges", cyc - acc, v.exp_lat);
        chk("rsp_data", rsp_data, v.exp_rsp);
        chk("tx_write_count", txlog.size(), 16);
        if (txlog.size() == 16) begin
            chk("tx_word0", txlog[0], v.exp_w0);
            chk("tx_word3", txlog[3], v.exp_w3);
            chk("tx_word15", txlog[15], v.exp_w15);
            chk("tx_span", wcyc[15] - wcyc[0], v.exp_span);
            chk("tx_gap_2_3", wcyc[3] - wcyc[2], v.stall ? 6 : 1);
            werr = 0;
            for (int i = 0; i < 16; i++) begin
                e = {(i == 15) ? 16'h1111 : 16'h0000, v.key[127-8*i -: 8], v.data[127-8*i -: 8]};
                if (txlog[i] !== e) werr++;
            end
            chk("tx_words", werr, 0);
        end
        held = rsp_data;
        bad  = 0;
        for (int i = 0; i < v.rsp_delay; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== held || tx_wr !== 1'b0 || rx_rd !== 1'b0) bad++;
        end
        if (v.rsp_delay > 0) chk("done_hold_stable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("back_to_idle", {busy, req_ready}, 2'b01);
    endtask

    initial begin
        int   a0;
        int   n;
        vec_t v;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_key   = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tx_full   = 1'b0;
        for (int i = 0; i < 16; i++) rx_arr[i] = 8'h00;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, 0, 1'b0,
                    32'h00000000, 32'h00000333, 32'h11110FFF, 15, 32,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b1, 10, 1'b0,
                    32'h00000000, 32'h00000333, 32'h11110FFF, 15, -1,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 1'b0, 0, 1'b0,
                    32'h00002B32, 32'h000016A8, 32'h11113C34, 20, -1,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[3] = '{128'hffffffffffffffffffffffffffffffff, 128'h00000000000000000000000000000000,
                    128'h0123456789abcdeffedcba9876543210, 1'b1, 1'b1, 3, 1'b0,
                    32'h0000FF00, 32'h0000FF00, 32'h1111FF00, 20, -1,
                    128'h0123456789abcdeffedcba9876543210};

        repeat (3) @(negedge clock);
        chk("reset_ctrl", {req_ready, busy, tx_wr, rx_rd, rsp_valid}, 5'b10000);
        chk("reset_tx_dout", tx_dout, 0);
        chk("reset_rsp_data", rsp_data, 0);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_txn(vecs[k]);

        // Reset in the middle of SEND abandons the block.
        cur_stall  = 1'b0;
        cur_toggle = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_key   = vecs[0].key;
        req_data  = vecs[0].data;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (tx_cnt < 5 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("five_writes_before_reset", tx_cnt, 5);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_ctrl", {req_ready, busy, tx_wr, rx_rd, rsp_valid}, 5'b10000);
        chk("async_reset_tx_dout", tx_dout, 0);
        chk("async_reset_rsp_data", rsp_data, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("no_stale_writes", tx_cnt, 5);
        run_txn(vecs[0]);

        // req_valid held high across a whole transaction.
        v      = vecs[0];
        v.hold = 1'b1;
        a0     = acc_cnt;
        run_txn(v);
        chk("no_accept_while_busy", acc_cnt - a0, 1);
        @(posedge clock);
        @(negedge clock);
        chk("second_accept_state", {busy, req_ready}, 2'b10);
        chk("second_accept_count", acc_cnt - a0, 2);
        req_valid = 1'b0;
        wait_rsp("second_rsp_timeout");
        chk("second_rsp_data", rsp_data, vecs[0].exp_rsp);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;

        chk("tx_wr_while_full", viol_full, 0);
        chk("rx_rd_while_empty", viol_empty, 0);
        chk("req_ready_vs_busy", viol_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
